// File: rtl/tof_peak_detector.sv
`default_nettype none
// ============================================================================
// tof_peak_detector: per-frame baseline, first threshold crossing and peak
// Revision: 1.0
// ============================================================================
module tof_peak_detector #(
  parameter int C_S00_AXIS_TDATA_WIDTH = 32,
  parameter int C_M00_AXIS_TDATA_WIDTH = 32,
  parameter int FRAME_LEN              = 1024,
  parameter int BASELINE_LEN           = 64
) (
  input  logic                                  s00_axis_aclk,
  input  logic                                  s00_axis_areset,
  input  logic                                  s00_axis_tvalid,
  input  logic                                  s00_axis_tlast,
  input  logic [C_S00_AXIS_TDATA_WIDTH-1:0]     s00_axis_tdata,
  input  logic [C_S00_AXIS_TDATA_WIDTH/8-1:0]   s00_axis_tstrb,
  output logic                                  s00_axis_tready,
  input  logic                                  m00_axis_tready,
  output logic                                  m00_axis_tvalid,
  output logic                                  m00_axis_tlast,
  output logic [C_M00_AXIS_TDATA_WIDTH-1:0]     m00_axis_tdata,
  output logic [C_M00_AXIS_TDATA_WIDTH/8-1:0]   m00_axis_tstrb,
  input  logic [15:0]                           threshold
);

  localparam int          C_LOG2B     = $clog2(BASELINE_LEN);
  localparam int          C_ACC_W     = 16 + C_LOG2B;
  localparam logic [9:0]  C_LAST_N    = 10'(FRAME_LEN - 1);
  localparam logic [9:0]  C_BASE_LAST = 10'(BASELINE_LEN - 1);
  localparam logic signed [16:0] C_PEAK_INIT = 17'h10000;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    BASELINE = 3'd1,
    SEARCH   = 3'd2,
    REPORT0  = 3'd3,
    REPORT1  = 3'd4
  } state_t;

  state_t r_state, w_state_next;

  logic                       r_s_tready;
  logic                       r_m_tvalid;
  logic                       r_m_tlast;
  logic [C_M00_AXIS_TDATA_WIDTH-1:0] r_m_tdata;
  logic [9:0]                 r_n;
  logic [15:0]                r_thresh;
  logic signed [C_ACC_W-1:0]  r_acc;
  logic signed [15:0]         r_baseline;
  logic signed [16:0]         r_peak_diff;
  logic [9:0]                 r_peak_idx;
  logic [9:0]                 r_first_idx;
  logic                       r_hit;
  logic                       r_seen;

  logic                       w_accept;
  logic                       w_m_xfer;
  logic                       w_frame_end;
  logic                       w_short;
  logic                       w_in_base;
  logic signed [15:0]         w_sample;
  logic signed [C_ACC_W-1:0]  w_acc_base;
  logic signed [C_ACC_W-1:0]  w_acc_sum;
  logic signed [C_ACC_W-1:0]  w_acc_shift;
  logic signed [16:0]         w_diff;
  logic signed [16:0]         w_thr;
  logic                       w_hit_n;
  logic                       w_seen_n;
  logic [9:0]                 w_first_n;
  logic [9:0]                 w_pidx_n;
  logic signed [16:0]         w_pdiff_n;
  logic [15:0]                w_amp;
  logic [31:0]                w_beat0;
  logic [31:0]                w_beat1;

  assign w_accept    = s00_axis_tvalid & r_s_tready;
  assign w_m_xfer    = r_m_tvalid & m00_axis_tready;
  assign w_sample    = s00_axis_tdata[15:0];
  assign w_frame_end = w_accept & (s00_axis_tlast | (r_n == C_LAST_N));
  assign w_short     = s00_axis_tlast & (r_n != C_LAST_N);
  assign w_in_base   = (r_state == IDLE) || (r_state == BASELINE);
  assign w_diff      = 17'(w_sample) - 17'(r_baseline);
  assign w_thr       = {1'b0, r_thresh};

  always_comb begin
    w_acc_base = (r_state == IDLE) ? '0 : r_acc;
    w_acc_sum  = w_acc_base + C_ACC_W'(w_sample);
  end
  assign w_acc_shift = w_acc_sum >>> C_LOG2B;

  // Search results as they stand after the current beat; IDLE starts a fresh frame
  always_comb begin
    w_hit_n   = r_hit;
    w_seen_n  = r_seen;
    w_first_n = r_first_idx;
    w_pidx_n  = r_peak_idx;
    w_pdiff_n = r_peak_diff;
    if (r_state == IDLE) begin
      w_hit_n   = 1'b0;
      w_seen_n  = 1'b0;
      w_first_n = '0;
      w_pidx_n  = '0;
      w_pdiff_n = C_PEAK_INIT;
    end else if (r_state == SEARCH && w_accept) begin
      w_seen_n = 1'b1;
      if (w_diff > r_peak_diff) begin
        w_pdiff_n = w_diff;
        w_pidx_n  = r_n;
      end
      if (!r_hit && (w_diff > w_thr)) begin
        w_hit_n   = 1'b1;
        w_first_n = r_n;
      end
    end
  end

  always_comb begin
    if (!r_seen)                          w_amp = 16'h0000;
    else if (r_peak_diff > 17'sd32767)    w_amp = 16'h7FFF;
    else if (r_peak_diff < -17'sd32768)   w_amp = 16'h8000;
    else                                  w_amp = r_peak_diff[15:0];
  end

  assign w_beat0 = {w_hit_n, w_short, 10'b0, w_first_n, w_pidx_n};
  assign w_beat1 = {r_baseline, w_amp};

  always_ff @(posedge s00_axis_aclk) begin
    if (s00_axis_areset) r_state <= IDLE;
    else                 r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE, BASELINE: begin
        if (w_accept) begin
          if (w_frame_end)              w_state_next = REPORT0;
          else if (r_n == C_BASE_LAST)  w_state_next = SEARCH;
          else                          w_state_next = BASELINE;
        end
      end
      SEARCH:  if (w_frame_end) w_state_next = REPORT0;
      REPORT0: if (w_m_xfer)    w_state_next = REPORT1;
      REPORT1: if (w_m_xfer)    w_state_next = IDLE;
      default:                  w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge s00_axis_aclk) begin
    if (s00_axis_areset) begin
      r_s_tready  <= 1'b0;
      r_m_tvalid  <= 1'b0;
      r_m_tlast   <= 1'b0;
      r_m_tdata   <= '0;
      r_n         <= '0;
      r_thresh    <= '0;
      r_acc       <= '0;
      r_baseline  <= '0;
      r_peak_diff <= C_PEAK_INIT;
      r_peak_idx  <= '0;
      r_first_idx <= '0;
      r_hit       <= 1'b0;
      r_seen      <= 1'b0;
    end else begin
      r_s_tready <= (w_state_next == IDLE) || (w_state_next == BASELINE) ||
                    (w_state_next == SEARCH);
      if (w_accept) begin
        r_n         <= w_frame_end ? 10'd0 : r_n + 10'd1;
        r_hit       <= w_hit_n;
        r_seen      <= w_seen_n;
        r_first_idx <= w_first_n;
        r_peak_idx  <= w_pidx_n;
        r_peak_diff <= w_pdiff_n;
        if (r_state == IDLE) r_thresh <= threshold;
        if (w_in_base) begin
          r_acc <= w_acc_sum;
          // A frame that ends early still reports the partial-sum baseline
          if (w_frame_end || (r_n == C_BASE_LAST)) r_baseline <= w_acc_shift[15:0];
        end
      end
      if (w_frame_end) begin
        r_m_tvalid <= 1'b1;
        r_m_tlast  <= 1'b0;
        r_m_tdata  <= C_M00_AXIS_TDATA_WIDTH'(w_beat0);
      end else if (w_m_xfer && r_state == REPORT0) begin
        r_m_tlast  <= 1'b1;
        r_m_tdata  <= C_M00_AXIS_TDATA_WIDTH'(w_beat1);
      end else if (w_m_xfer && r_state == REPORT1) begin
        r_m_tvalid <= 1'b0;
        r_m_tlast  <= 1'b0;
        r_m_tdata  <= '0;
      end
    end
  end

  assign s00_axis_tready = r_s_tready;
  assign m00_axis_tvalid = r_m_tvalid;
  assign m00_axis_tlast  = r_m_tlast;
  assign m00_axis_tdata  = r_m_tdata;
  assign m00_axis_tstrb  = '1;

  generate
    if (C_S00_AXIS_TDATA_WIDTH > 16) begin : g_upper_unused
      logic w_unused_upper;
      assign w_unused_upper = |s00_axis_tdata[C_S00_AXIS_TDATA_WIDTH-1:16];
    end
  endgenerate

  logic w_unused_strb;
  assign w_unused_strb = |s00_axis_tstrb;

endmodule
`default_nettype wire

// File: tb/tb_tof_peak_detector.sv
`default_nettype none
// ============================================================================
// tb_tof_peak_detector: directed frames with hand-computed result records
// Revision: 1.0
// ============================================================================
module tb_tof_peak_detector;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        s_tvalid = 1'b0;
  logic        s_tlast = 1'b0;
  logic [31:0] s_tdata = '0;
  logic [3:0]  s_tstrb = 4'hF;
  logic        s_tready;
  logic        m_tready = 1'b1;
  logic        m_tvalid;
  logic        m_tlast;
  logic [31:0] m_tdata;
  logic [3:0]  m_tstrb;
  logic [15:0] thr = '0;

  int          tests = 0;
  int          fails = 0;
  logic [15:0] frame [0:1023];
  int          thr_at = -1;
  logic [15:0] thr_new = '0;

  tof_peak_detector #(
    .C_S00_AXIS_TDATA_WIDTH(32),
    .C_M00_AXIS_TDATA_WIDTH(32),
    .FRAME_LEN(1024),
    .BASELINE_LEN(64)
  ) dut (
    .s00_axis_aclk(clk),
    .s00_axis_areset(rst),
    .s00_axis_tvalid(s_tvalid),
    .s00_axis_tlast(s_tlast),
    .s00_axis_tdata(s_tdata),
    .s00_axis_tstrb(s_tstrb),
    .s00_axis_tready(s_tready),
    .m00_axis_tready(m_tready),
    .m00_axis_tvalid(m_tvalid),
    .m00_axis_tlast(m_tlast),
    .m00_axis_tdata(m_tdata),
    .m00_axis_tstrb(m_tstrb),
    .threshold(thr)
  );

  always #5 clk = ~clk;

  // Called at a negedge; returns at the negedge after the beat is accepted
  task automatic send(input logic [15:0] d, input logic last);
    int k = 0;
    s_tdata  = {16'hA5A5, d};
    s_tlast  = last;
    s_tvalid = 1'b1;
    while (!s_tready && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (!s_tready) begin
      tests++; fails++;
      $display("FAIL send_timeout tready=%b required 1", s_tready);
    end
    @(negedge clk);
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  task automatic send_frame(input int len, input logic use_last);
    for (int i = 0; i < len; i++) begin
      if (i == thr_at) thr = thr_new;
      send(frame[i], use_last && (i == len - 1));
    end
  endtask

  task automatic fill(input logic [15:0] v);
    for (int i = 0; i < 1024; i++) frame[i] = v;
  endtask

  task automatic get_record(output logic [31:0] b0, output logic [31:0] b1,
                            output logic l0, output logic l1, output logic ok);
    int k = 0;
    ok = 1'b0; b0 = '0; b1 = '0; l0 = 1'b0; l1 = 1'b0;
    while (!m_tvalid && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (m_tvalid) begin
      b0 = m_tdata; l0 = m_tlast;
      @(negedge clk);
      ok = m_tvalid; b1 = m_tdata; l1 = m_tlast;
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    tests++;
    if (s_tready !== 1'b0) begin fails++; $display("FAIL reset_s_tready got %b required 0", s_tready); end
    tests++;
    if ({m_tvalid, m_tlast} !== 2'b00) begin fails++; $display("FAIL reset_m_valid_last got %b required 00", {m_tvalid, m_tlast}); end
    tests++;
    if (m_tdata !== 32'h0) begin fails++; $display("FAIL reset_m_tdata got %h required 0", m_tdata); end
    tests++;
    if (m_tstrb !== 4'hF) begin fails++; $display("FAIL reset_m_tstrb got %h required f", m_tstrb); end
    rst = 1'b0;
    @(negedge clk);
    tests++;
    if (s_tready !== 1'b1) begin fails++; $display("FAIL reset_release_tready got %b required 1", s_tready); end
  endtask

  task automatic test_basic;
    logic [31:0] b0, b1; logic l0, l1, ok;
    thr = 16'd100;
    fill(16'd10);
    frame[500] = 16'd300;
    frame[501] = 16'd400;
    send_frame(1024, 1'b0);
    tests++;
    if ({m_tvalid, s_tready} !== 2'b10) begin fails++; $display("FAIL basic_handover valid,ready got %b required 10", {m_tvalid, s_tready}); end
    get_record(b0, b1, l0, l1, ok);
    tests++;
    if ({ok, l0, l1} !== 3'b101) begin fails++; $display("FAIL basic_framing ok,l0,l1 got %b required 101", {ok, l0, l1}); end
    tests++;
    if (b0 !== {1'b1, 1'b0, 10'd0, 10'd500, 10'd501}) begin fails++; $display("FAIL basic_beat0 got %h required %h", b0, {1'b1, 1'b0, 10'd0, 10'd500, 10'd501}); end
    tests++;
    if (b1 !== {16'd10, 16'd390}) begin fails++; $display("FAIL basic_beat1 got %h required %h", b1, {16'd10, 16'd390}); end
    tests++;
    if ({m_tvalid, s_tready} !== 2'b01) begin fails++; $display("FAIL basic_return_idle valid,ready got %b required 01", {m_tvalid, s_tready}); end
  endtask

  task automatic test_flat;
    logic [31:0] b0, b1; logic l0, l1, ok;
    thr = 16'd0;
    fill(16'hFFFB);
    send_frame(1024, 1'b1);
    get_record(b0, b1, l0, l1, ok);
    tests++;
    if ({ok, l0, l1} !== 3'b101) begin fails++; $display("FAIL flat_framing got %b required 101", {ok, l0, l1}); end
    tests++;
    if (b0 !== 32'd64) begin fails++; $display("FAIL flat_beat0 got %h required %h", b0, 32'd64); end
    tests++;
    if (b1 !== 32'hFFFB_0000) begin fails++; $display("FAIL flat_beat1 got %h required fffb0000", b1); end
  endtask

  task automatic test_tie_floor;
    logic [31:0] b0, b1; logic l0, l1, ok;
    thr = 16'd500;
    fill(16'd0);
    for (int i = 0; i < 64; i++) frame[i] = (i % 2 == 1) ? 16'h8000 : 16'h7FFF;
    frame[200] = 16'd1000;
    frame[700] = 16'd1000;
    send_frame(1024, 1'b0);
    get_record(b0, b1, l0, l1, ok);
    tests++;
    if (ok !== 1'b1) begin fails++; $display("FAIL tie_record got %b required 1", ok); end
    tests++;
    if (b0 !== {1'b1, 1'b0, 10'd0, 10'd200, 10'd200}) begin fails++; $display("FAIL tie_beat0 got %h required %h", b0, {1'b1, 1'b0, 10'd0, 10'd200, 10'd200}); end
    tests++;
    if (b1 !== {16'hFFFF, 16'd1001}) begin fails++; $display("FAIL floor_beat1 got %h required %h", b1, {16'hFFFF, 16'd1001}); end
  endtask

  task automatic test_short;
    logic [31:0] b0, b1; logic l0, l1, ok;
    thr = 16'd0;
    fill(16'hFF9C);
    send_frame(31, 1'b1);
    get_record(b0, b1, l0, l1, ok);
    tests++;
    if ({ok, l0, l1} !== 3'b101) begin fails++; $display("FAIL short_framing got %b required 101", {ok, l0, l1}); end
    tests++;
    if (b0 !== 32'h4000_0000) begin fails++; $display("FAIL short_beat0 got %h required 40000000", b0); end
    tests++;
    if (b1 !== 32'hFFCF_0000) begin fails++; $display("FAIL short_beat1 got %h required ffcf0000", b1); end
  endtask

  task automatic test_base_tlast;
    logic [31:0] b0, b1; logic l0, l1, ok;
    thr = 16'd0;
    fill(16'd7);
    send_frame(64, 1'b1);
    get_record(b0, b1, l0, l1, ok);
    tests++;
    if (ok !== 1'b1) begin fails++; $display("FAIL base_tlast_record got %b required 1", ok); end
    tests++;
    if (b0 !== 32'h4000_0000) begin fails++; $display("FAIL base_tlast_beat0 got %h required 40000000", b0); end
    tests++;
    if (b1 !== 32'h0007_0000) begin fails++; $display("FAIL base_tlast_beat1 got %h required 00070000", b1); end
  endtask

  task automatic test_thr_latch;
    logic [31:0] b0, b1; logic l0, l1, ok;
    thr = 16'd1000;
    fill(16'd10);
    frame[500] = 16'd300;
    thr_at = 10;
    thr_new = 16'd0;
    send_frame(1024, 1'b0);
    thr_at = -1;
    get_record(b0, b1, l0, l1, ok);
    tests++;
    if (b0 !== {1'b0, 1'b0, 10'd0, 10'd0, 10'd500}) begin fails++; $display("FAIL thr_latch_beat0 got %h required %h", b0, {1'b0, 1'b0, 10'd0, 10'd0, 10'd500}); end
    tests++;
    if (b1 !== {16'd10, 16'd290}) begin fails++; $display("FAIL thr_latch_beat1 got %h required %h", b1, {16'd10, 16'd290}); end
  endtask

  task automatic test_backpressure;
    logic [31:0] b0, b1; logic l0, l1, ok;
    int bad = 0;
    m_tready = 1'b0;
    thr = 16'd100;
    fill(16'd10);
    frame[500] = 16'd300;
    frame[501] = 16'd400;
    send_frame(1024, 1'b0);
    s_tvalid = 1'b1; s_tlast = 1'b1; s_tdata = 32'h0000_1234;
    repeat (20) begin
      @(negedge clk);
      tests++;
      if ({m_tvalid, m_tlast, s_tready} !== 3'b100 ||
          m_tdata !== {1'b1, 1'b0, 10'd0, 10'd500, 10'd501}) begin
        fails++; bad++;
        if (bad == 1) $display("FAIL stall_hold valid,last,ready=%b data=%h required 100 %h",
                               {m_tvalid, m_tlast, s_tready}, m_tdata, {1'b1, 1'b0, 10'd0, 10'd500, 10'd501});
      end
    end
    s_tvalid = 1'b0; s_tlast = 1'b0;
    m_tready = 1'b1;
    get_record(b0, b1, l0, l1, ok);
    tests++;
    if ({ok, l0, l1} !== 3'b101) begin fails++; $display("FAIL stall_framing got %b required 101", {ok, l0, l1}); end
    tests++;
    if (b1 !== {16'd10, 16'd390}) begin fails++; $display("FAIL stall_beat1 got %h required %h", b1, {16'd10, 16'd390}); end
  endtask

  task automatic test_reset_mid;
    logic [31:0] b0, b1; logic l0, l1, ok;
    logic seen;
    thr = 16'd0;
    fill(16'd10);
    send_frame(600, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    repeat (10) begin @(negedge clk); if (m_tvalid) seen = 1'b1; end
    tests++;
    if (seen !== 1'b0) begin fails++; $display("FAIL reset_mid_frame_output got %b required 0", seen); end
    fill(16'hFFFB);
    send_frame(1024, 1'b1);
    get_record(b0, b1, l0, l1, ok);
    tests++;
    if (b0 !== 32'd64 || b1 !== 32'hFFFB_0000) begin fails++; $display("FAIL reset_mid_next_record got %h %h required 00000040 fffb0000", b0, b1); end

    m_tready = 1'b0;
    send_frame(1024, 1'b1);
    tests++;
    if (m_tvalid !== 1'b1) begin fails++; $display("FAIL report_entry valid got %b required 1", m_tvalid); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    m_tready = 1'b1;
    seen = 1'b0;
    repeat (10) begin @(negedge clk); if (m_tvalid) seen = 1'b1; end
    tests++;
    if (seen !== 1'b0) begin fails++; $display("FAIL reset_report_output got %b required 0", seen); end
    test_basic();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_flat();
    test_tie_floor();
    test_short();
    test_basic();
    test_base_tlast();
    test_thr_latch();
    test_backpressure();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
